// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures high time and rise-to-rise period of each frame,
// validates it and publishes width, period and an 8-bit position code.
// Optional input deglitch filter enabled by defining SERVO_DEC_DEGLITCH_EN.
module servo_pulse_decoder #(
    parameter int unsigned CLK_FREQ        = 25_000_000,
    parameter int unsigned PERIOD          = 500_000,
    parameter int unsigned WIDTH_TOL       = PERIOD / 100,
    parameter int unsigned PERIOD_TOL      = PERIOD / 10,
    parameter int unsigned TIMEOUT         = 2 * PERIOD,
    parameter int unsigned DEGLITCH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        servo_in,
    output logic [31:0] pulse_width,
    output logic [31:0] period_meas,
    output logic [7:0]  position,
    output logic        sample_valid,
    output logic        frame_err,
    output logic        signal_lost
);

    localparam logic [32:0] MIN_W   = 33'(PERIOD / 20);
    localparam logic [32:0] MAX_W   = 33'(PERIOD / 10);
    localparam logic [32:0] W_TOL   = 33'(WIDTH_TOL);
    localparam logic [32:0] P_NOM   = 33'(PERIOD);
    localparam logic [32:0] P_TOL   = 33'(PERIOD_TOL);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
    localparam logic [39:0] SPAN    = 40'(PERIOD / 10 - PERIOD / 20);

    if (PERIOD < 20) begin : g_bad_period
        $error("servo_pulse_decoder: PERIOD must be at least 20");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("servo_pulse_decoder: TIMEOUT must be non-zero");
    end
    if (DEGLITCH_CYCLES == 0) begin : g_bad_deglitch
        $error("servo_pulse_decoder: DEGLITCH_CYCLES must be non-zero");
    end
    if (CLK_FREQ == 0) begin : g_bad_clk
        $error("servo_pulse_decoder: CLK_FREQ must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_e;

    // Saturate a measured width into the [MIN_W, MAX_W] servo window.
    function automatic logic [31:0] sat_width(input logic [31:0] w);
        logic [31:0] c;
        c = w;
        if ({1'b0, w} < MIN_W) begin
            c = MIN_W[31:0];
        end else if ({1'b0, w} > MAX_W) begin
            c = MAX_W[31:0];
        end
        return c;
    endfunction

    // Map a saturated width onto 0..255, truncating.
    function automatic logic [7:0] pos_scale(input logic [31:0] w);
        return 8'(((40'(w) - 40'(MIN_W[31:0])) * 40'd255) / SPAN);
    endfunction

    function automatic logic frame_ok(input logic [31:0] hi, input logic [31:0] per);
        logic [32:0] h33;
        logic [32:0] p33;
        h33 = {1'b0, hi};
        p33 = {1'b0, per};
        return (h33 + W_TOL >= MIN_W) && (h33 <= MAX_W + W_TOL) &&
               (p33 + P_TOL >= P_NOM) && (p33 <= P_NOM + P_TOL);
    endfunction

    logic meta_q;
    logic sync_q;
    logic clean;
    logic edge_q;
    logic rise;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= servo_in;
            sync_q <= meta_q;
        end
    end

`ifdef SERVO_DEC_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_CYCLES + 1);

    logic [DG_W-1:0] dg_cnt_q;
    logic            filt_q;

    // Follow the synchronized input only after it holds a new level long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dg_cnt_q <= '0;
            filt_q   <= 1'b0;
        end else if (sync_q == filt_q) begin
            dg_cnt_q <= '0;
        end else if (dg_cnt_q == DG_W'(DEGLITCH_CYCLES - 1)) begin
            dg_cnt_q <= '0;
            filt_q   <= sync_q;
        end else begin
            dg_cnt_q <= dg_cnt_q + DG_W'(1);
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= clean;
        end
    end

    assign rise = clean & ~edge_q;
    assign fall = ~clean & edge_q;

    state_e      state_q,    state_d;
    logic [31:0] hi_cnt_q,   hi_cnt_d;
    logic [31:0] per_cnt_q,  per_cnt_d;
    logic [31:0] wd_cnt_q,   wd_cnt_d;
    logic [31:0] pw_q,       pw_d;
    logic [31:0] per_meas_q, per_meas_d;
    logic [7:0]  pos_q,      pos_d;
    logic        sv_q,       sv_d;
    logic        fe_q,       fe_d;
    logic        lost_q,     lost_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hi_cnt_q   <= '0;
            per_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            pw_q       <= '0;
            per_meas_q <= '0;
            pos_q      <= '0;
            sv_q       <= 1'b0;
            fe_q       <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hi_cnt_q   <= hi_cnt_d;
            per_cnt_q  <= per_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            pw_q       <= pw_d;
            per_meas_q <= per_meas_d;
            pos_q      <= pos_d;
            sv_q       <= sv_d;
            fe_q       <= fe_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_cnt_d   = hi_cnt_q;
        per_cnt_d  = per_cnt_q;
        wd_cnt_d   = wd_cnt_q + 32'd1;
        pw_d       = pw_q;
        per_meas_d = per_meas_q;
        pos_d      = pos_q;
        sv_d       = 1'b0;
        fe_d       = 1'b0;
        lost_d     = lost_q;

        if (rise || fall) begin
            wd_cnt_d = '0;
        end

        // The fall cycle already belongs to the low part of the frame.
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    hi_cnt_d  = 32'd1;
                    per_cnt_d = 32'd1;
                    state_d   = S_HIGH;
                end
            end
            S_HIGH: begin
                per_cnt_d = per_cnt_q + 32'd1;
                if (fall) begin
                    state_d = S_LOW;
                end else begin
                    hi_cnt_d = hi_cnt_q + 32'd1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    if (frame_ok(hi_cnt_q, per_cnt_q)) begin
                        pw_d       = hi_cnt_q;
                        per_meas_d = per_cnt_q;
                        pos_d      = pos_scale(sat_width(hi_cnt_q));
                        sv_d       = 1'b1;
                        lost_d     = 1'b0;
                    end else begin
                        fe_d = 1'b1;
                    end
                    hi_cnt_d  = 32'd1;
                    per_cnt_d = 32'd1;
                    state_d   = S_HIGH;
                end else begin
                    per_cnt_d = per_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An edge in the expiry cycle keeps the frame alive.
        if (!rise && !fall && wd_cnt_q == WD_LAST) begin
            state_d   = S_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
            wd_cnt_d  = '0;
            lost_d    = 1'b1;
        end
    end

    assign pulse_width  = pw_q;
    assign period_meas  = per_meas_q;
    assign position     = pos_q;
    assign sample_valid = sv_q;
    assign frame_err    = fe_q;
    assign signal_lost  = lost_q;

endmodule
